// File: rtl/fht_stream_io.sv
`default_nettype none
// ============================================================================
//  Module   : fht_stream_io
//  Purpose  : Streaming host-side front/back end for the FHT core. Loads one
//             frame of N = 4*2^A_BIT samples from a valid/ready stream into the
//             core's four RAM(A) banks, strobes start, waits out the transform
//             and streams the results back in natural order with a last flag.
//  Options  : FHT_IO_BITREV_EN - write sample k at point index bitrev(k).
//  Revision : 1.0 - initial release
// ============================================================================
module fht_stream_io #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic [D_BIT-2:0]   iS_DATA,
    input  logic               iS_VALID,
    output logic               oS_READY,
    output logic [D_BIT-1:0]   oM_DATA,
    output logic               oM_VALID,
    input  logic               iM_READY,
    output logic               oM_LAST,
    output logic [D_BIT-2:0]   oFHT_DATA,
    output logic [A_BIT-1:0]   oFHT_ADDR_WR,
    output logic               oFHT_WE_0,
    output logic               oFHT_WE_1,
    output logic               oFHT_WE_2,
    output logic               oFHT_WE_3,
    output logic               oFHT_START,
    output logic [A_BIT-1:0]   oFHT_ADDR_RD_0,
    output logic [A_BIT-1:0]   oFHT_ADDR_RD_1,
    output logic [A_BIT-1:0]   oFHT_ADDR_RD_2,
    output logic [A_BIT-1:0]   oFHT_ADDR_RD_3,
    input  logic [D_BIT-1:0]   iFHT_DATA_0,
    input  logic [D_BIT-1:0]   iFHT_DATA_1,
    input  logic [D_BIT-1:0]   iFHT_DATA_2,
    input  logic [D_BIT-1:0]   iFHT_DATA_3,
    input  logic               iFHT_RDY,
    output logic               oBUSY
);

    localparam int              K_BIT  = A_BIT + 2;
    localparam logic [K_BIT-1:0] K_LAST = '1;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_UNLOAD  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;

    // Load path
    logic [K_BIT-1:0]   wr_cnt_q;
    logic [K_BIT-1:0]   w_wr_idx;
    logic [D_BIT-2:0]   wr_data_q;
    logic [A_BIT-1:0]   wr_addr_q;
    logic [3:0]         wr_we_q;
    logic               w_s_fire;

    // Unload path: read issue, one in-flight read, 2-entry output FIFO
    logic [K_BIT-1:0]   rd_cnt_q;
    logic               rd_all_q;
    logic               pend_q;
    logic [1:0]         pend_bank_q;
    logic               pend_last_q;
    logic [D_BIT-1:0]   fifo_data_q [0:1];
    logic               fifo_last_q [0:1];
    logic               fifo_wp_q, fifo_rp_q;
    logic [1:0]         fifo_cnt_q;
    logic [D_BIT-1:0]   w_rd_data;
    logic [2:0]         w_occ;
    logic               w_pop, w_issue, w_last_fire;

`ifdef FHT_IO_BITREV_EN
    for (genvar i = 0; i < K_BIT; i++) begin : g_bitrev
        assign w_wr_idx[i] = wr_cnt_q[K_BIT-1-i];
    end
`else
    assign w_wr_idx = wr_cnt_q;
`endif

    assign w_s_fire    = iS_VALID && (state_q == S_LOAD);
    assign w_pop       = oM_VALID && iM_READY;
    assign w_last_fire = w_pop && oM_LAST;
    // Occupancy after this cycle's pop; a new read may only be issued while
    // the FIFO is guaranteed a free slot when its data returns.
    assign w_occ       = {1'b0, fifo_cnt_q} + {2'b00, pend_q} - {2'b00, w_pop};
    assign w_issue     = (state_q == S_UNLOAD) && !rd_all_q && (w_occ < 3'd2);

    // Select the bank addressed by the read issued in the previous cycle
    always_comb begin
        w_rd_data = iFHT_DATA_0;
        case (pend_bank_q)
            2'd1:    w_rd_data = iFHT_DATA_1;
            2'd2:    w_rd_data = iFHT_DATA_2;
            2'd3:    w_rd_data = iFHT_DATA_3;
            default: w_rd_data = iFHT_DATA_0;
        endcase
    end

    // Frame sequencing: next state and start strobe request
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        case (state_q)
            S_LOAD:    if (w_s_fire && (wr_cnt_q == K_LAST)) state_d = S_START;
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: if (!iFHT_RDY) state_d = S_WAIT_HI;
            S_WAIT_HI: if (iFHT_RDY)  state_d = S_UNLOAD;
            S_UNLOAD:  if (w_last_fire) state_d = S_LOAD;
            default:   state_d = S_LOAD;
        endcase
    end

    // State register and registered start strobe
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_LOAD;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Register each accepted sample onto the core write port, one bank per beat
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            wr_cnt_q  <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_we_q   <= '0;
        end else begin
            wr_we_q <= '0;
            if (w_s_fire) begin
                wr_data_q <= iS_DATA;
                wr_addr_q <= w_wr_idx[K_BIT-1:2];
                wr_we_q   <= 4'b0001 << w_wr_idx[1:0];
                wr_cnt_q  <= wr_cnt_q + 1'b1;
            end else if (w_last_fire) begin
                wr_cnt_q  <= '0;
            end
        end
    end

    // Issue reads in natural order and remember which bank/point is in flight
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_cnt_q    <= '0;
            rd_all_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 2'd0;
            pend_last_q <= 1'b0;
        end else begin
            pend_q <= w_issue;
            if (w_issue) begin
                pend_bank_q <= rd_cnt_q[1:0];
                pend_last_q <= (rd_cnt_q == K_LAST);
                rd_cnt_q    <= rd_cnt_q + 1'b1;
                if (rd_cnt_q == K_LAST) rd_all_q <= 1'b1;
            end
            if ((state_q == S_WAIT_HI) && iFHT_RDY) begin
                rd_cnt_q <= '0;
                rd_all_q <= 1'b0;
            end
        end
    end

    // Output FIFO: push returning RAM data, pop on sink handshake
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (pend_q) begin
                fifo_data_q[fifo_wp_q] <= w_rd_data;
                fifo_last_q[fifo_wp_q] <= pend_last_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (w_pop) fifo_rp_q <= ~fifo_rp_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, w_pop};
        end
    end

    assign oS_READY       = (state_q == S_LOAD);
    assign oBUSY          = (state_q != S_LOAD);
    assign oM_VALID       = (fifo_cnt_q != 2'd0);
    assign oM_DATA        = fifo_data_q[fifo_rp_q];
    assign oM_LAST        = oM_VALID && fifo_last_q[fifo_rp_q];
    assign oFHT_DATA      = wr_data_q;
    assign oFHT_ADDR_WR   = wr_addr_q;
    assign oFHT_WE_0      = wr_we_q[0];
    assign oFHT_WE_1      = wr_we_q[1];
    assign oFHT_WE_2      = wr_we_q[2];
    assign oFHT_WE_3      = wr_we_q[3];
    assign oFHT_START     = start_q;
    assign oFHT_ADDR_RD_0 = rd_cnt_q[K_BIT-1:2];
    assign oFHT_ADDR_RD_1 = rd_cnt_q[K_BIT-1:2];
    assign oFHT_ADDR_RD_2 = rd_cnt_q[K_BIT-1:2];
    assign oFHT_ADDR_RD_3 = rd_cnt_q[K_BIT-1:2];

endmodule
`default_nettype wire

// File: tb/tb_fht_stream_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fht_stream_io
//  Purpose  : Directed self-checking bench for fht_stream_io (A_BIT=3, N=32)
//             with a small FHT core model (bank RAMs + ready handshake).
//             Expected write indices follow FHT_IO_BITREV_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fht_stream_io;

    localparam int D_BIT = 17;
    localparam int A_BIT = 3;
    localparam int N     = 32;

    logic               iCLK = 1'b0;
    logic               iRESET;
    logic [D_BIT-2:0]   iS_DATA;
    logic               iS_VALID;
    logic               oS_READY;
    logic [D_BIT-1:0]   oM_DATA;
    logic               oM_VALID;
    logic               iM_READY = 1'b1;
    logic               oM_LAST;
    logic [D_BIT-2:0]   oFHT_DATA;
    logic [A_BIT-1:0]   oFHT_ADDR_WR;
    logic               oFHT_WE_0, oFHT_WE_1, oFHT_WE_2, oFHT_WE_3;
    logic               oFHT_START;
    logic [A_BIT-1:0]   oFHT_ADDR_RD_0, oFHT_ADDR_RD_1, oFHT_ADDR_RD_2, oFHT_ADDR_RD_3;
    logic [D_BIT-1:0]   iFHT_DATA_0, iFHT_DATA_1, iFHT_DATA_2, iFHT_DATA_3;
    logic               iFHT_RDY = 1'b1;
    logic               oBUSY;

    fht_stream_io #(.D_BIT(D_BIT), .A_BIT(A_BIT)) u_dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
        .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY), .oM_LAST(oM_LAST),
        .oFHT_DATA(oFHT_DATA), .oFHT_ADDR_WR(oFHT_ADDR_WR),
        .oFHT_WE_0(oFHT_WE_0), .oFHT_WE_1(oFHT_WE_1), .oFHT_WE_2(oFHT_WE_2), .oFHT_WE_3(oFHT_WE_3),
        .oFHT_START(oFHT_START),
        .oFHT_ADDR_RD_0(oFHT_ADDR_RD_0), .oFHT_ADDR_RD_1(oFHT_ADDR_RD_1),
        .oFHT_ADDR_RD_2(oFHT_ADDR_RD_2), .oFHT_ADDR_RD_3(oFHT_ADDR_RD_3),
        .iFHT_DATA_0(iFHT_DATA_0), .iFHT_DATA_1(iFHT_DATA_1),
        .iFHT_DATA_2(iFHT_DATA_2), .iFHT_DATA_3(iFHT_DATA_3),
        .iFHT_RDY(iFHT_RDY), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Per-frame stimulus and expected read-back contents
    logic [D_BIT-2:0] samp   [0:N-1];
    logic [D_BIT-1:0] rd_mem [0:N-1];

    // Core model: synchronous-read bank RAMs, point index = {addr, bank}
    always @(posedge iCLK) begin
        iFHT_DATA_0 <= rd_mem[{oFHT_ADDR_RD_0, 2'd0}];
        iFHT_DATA_1 <= rd_mem[{oFHT_ADDR_RD_1, 2'd1}];
        iFHT_DATA_2 <= rd_mem[{oFHT_ADDR_RD_2, 2'd2}];
        iFHT_DATA_3 <= rd_mem[{oFHT_ADDR_RD_3, 2'd3}];
    end

    // Core model: ready drops 3 cycles after start, returns 100 cycles later
    int core_cnt = 0;
    always @(posedge iCLK) begin
        if (oFHT_START) core_cnt <= 1;
        else if (core_cnt != 0) core_cnt <= core_cnt + 1;
        if (core_cnt == 3) iFHT_RDY <= 1'b0;
        if (core_cnt == 103) begin
            iFHT_RDY <= 1'b1;
            core_cnt <= 0;
        end
    end

    function automatic logic [4:0] exp_idx(input int k);
        logic [4:0] kk;
        kk = 5'(k);
`ifdef FHT_IO_BITREV_EN
        return {kk[0], kk[1], kk[2], kk[3], kk[4]};
`else
        return kk;
`endif
    endfunction

    // Sink back-pressure: always ready, or a coin flip every cycle
    logic rnd_ready = 1'b0;
    initial forever begin
        @(posedge iCLK);
        #1;
        iM_READY = rnd_ready ? ($urandom_range(1) == 1) : 1'b1;
    end

    // Monitor, sampled on the falling edge
    int cyc = 0, hs_cnt = 0, wr_k = 0, start_cnt = 0, beat = 0;
    int last_hs_cyc = 0, last_we_cyc = 0, start_cyc = 0, rise_cyc = 0;
    int first_valid_cyc = 0, last_beat_cyc = 0;
    logic got_first = 1'b0, rdy_prev = 1'b1, stall_prev = 1'b0, prev_last = 1'b0;
    logic [D_BIT-1:0] prev_data = '0;
    logic [4:0] idx;

    always @(negedge iCLK) begin
        cyc++;
        if (!iRESET) begin
            stall_prev = 1'b0;
        end else begin
            if (iS_VALID && oS_READY) begin
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if ({oFHT_WE_3, oFHT_WE_2, oFHT_WE_1, oFHT_WE_0} != 4'd0) begin
                chk("we_in_frame", 32'(wr_k < N), 1);
                if (wr_k < N) begin
                    idx = exp_idx(wr_k);
                    chk("wr_we", {oFHT_WE_3, oFHT_WE_2, oFHT_WE_1, oFHT_WE_0}, 32'(4'b0001 << idx[1:0]));
                    chk("wr_addr", oFHT_ADDR_WR, idx[4:2]);
                    chk("wr_data", oFHT_DATA, samp[wr_k]);
                end
                wr_k++;
                last_we_cyc = cyc;
            end
            if (oFHT_START) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (iFHT_RDY && !rdy_prev) rise_cyc = cyc;
            if (oM_VALID && !got_first) begin
                got_first = 1'b1;
                first_valid_cyc = cyc;
            end
            if (stall_prev) begin
                chk("hold_valid", oM_VALID, 1);
                chk("hold_data", oM_DATA, prev_data);
                chk("hold_last", oM_LAST, prev_last);
            end
            if (oM_VALID && iM_READY) begin
                chk("beat_in_frame", 32'(beat < N), 1);
                if (beat < N) begin
                    chk("rd_data", oM_DATA, rd_mem[beat]);
                    chk("rd_last", oM_LAST, 32'(beat == N-1));
                end
                beat++;
                last_beat_cyc = cyc;
            end
            stall_prev = oM_VALID && !iM_READY;
            prev_data  = oM_DATA;
            prev_last  = oM_LAST;
        end
        rdy_prev = iFHT_RDY;
    end

    task automatic check_reset_outputs();
        chk("rst_s_ready", oS_READY, 1);
        chk("rst_busy", oBUSY, 0);
        chk("rst_m_valid", oM_VALID, 0);
        chk("rst_m_last", oM_LAST, 0);
        chk("rst_m_data", oM_DATA, 0);
        chk("rst_we", {oFHT_WE_3, oFHT_WE_2, oFHT_WE_1, oFHT_WE_0}, 0);
        chk("rst_start", oFHT_START, 0);
        chk("rst_addr_wr", oFHT_ADDR_WR, 0);
        chk("rst_fht_data", oFHT_DATA, 0);
        chk("rst_addr_rd", {oFHT_ADDR_RD_3, oFHT_ADDR_RD_2, oFHT_ADDR_RD_1, oFHT_ADDR_RD_0}, 0);
    endtask

    task automatic fill(input int f);
        for (int k = 0; k < N; k++) begin
            samp[k]   = 16'(k + 32*f);
            rd_mem[k] = 17'(k);
        end
        if (f == 1) begin
            samp[7]   = 16'hFFFF;
            rd_mem[5] = 17'h1FFFF;
        end
    endtask

    task automatic load_frame();
        int k, n;
        logic acc;
        wr_k = 0; hs_cnt = 0; start_cnt = 0; beat = 0; got_first = 1'b0;
        k = 0; n = 0;
        while (k < N && n < 200) begin
            iS_VALID = 1'b1;
            iS_DATA  = samp[k];
            @(negedge iCLK);
            acc = oS_READY;
            @(posedge iCLK);
            #1;
            if (acc) k++;
            n++;
        end
        iS_VALID = 1'b0;
        chk("load_done", k, N);
        chk("load_full_rate", n, N);
        n = 0;
        while (start_cnt == 0 && n < 20) begin
            @(posedge iCLK);
            #1;
            n++;
        end
        repeat (4) @(posedge iCLK);
        #1;
        chk("start_count", start_cnt, 1);
        chk("hs_count", hs_cnt, N);
        chk("we_count", wr_k, N);
        chk("we_latency", 32'(last_we_cyc - last_hs_cyc), 1);
        chk("start_latency", 32'(start_cyc - last_hs_cyc), 2);
        chk("busy_after_load", oBUSY, 1);
        chk("no_ready_after_load", oS_READY, 0);
    endtask

    task automatic unload_wait(input int upto);
        int n;
        n = 0;
        while (beat < upto && n < 600) begin
            @(posedge iCLK);
            #1;
            n++;
        end
        chk("unload_beats", beat, upto);
    endtask

    task automatic finish_frame(input logic full_rate);
        unload_wait(N);
        chk("first_valid_latency", 32'(first_valid_cyc - rise_cyc), 3);
        if (full_rate) chk("unload_rate", 32'(last_beat_cyc - first_valid_cyc), N-1);
        chk("idle_s_ready", oS_READY, 1);
        chk("idle_busy", oBUSY, 0);
        chk("idle_m_valid", oM_VALID, 0);
    endtask

    initial begin
        iRESET   = 1'b0;
        iS_VALID = 1'b0;
        iS_DATA  = '0;
        fill(0);
        repeat (3) @(posedge iCLK);
        #1;
        check_reset_outputs();
        iRESET = 1'b1;
        @(posedge iCLK);
        #1;

        // Ramp with one all-ones sample; read-back includes a negative point
        fill(1);
        load_frame();
        finish_frame(1'b1);

        // Random sink back-pressure
        fill(2);
        rnd_ready = 1'b1;
        load_frame();
        finish_frame(1'b0);
        rnd_ready = 1'b0;

        // Reset while point 17 is on the output
        fill(3);
        load_frame();
        unload_wait(17);
        iRESET = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge iCLK);
        #1;
        iRESET = 1'b1;

        // Normal frame after the mid-unload reset
        fill(4);
        load_frame();
        finish_frame(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
